// File: rtl/srfifo_pkg.sv
// Shared definitions for the shift-register FIFO: counter width helper and
// the {push_ena, pop_ena} operation encoding.
package srfifo_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_BOTH = 2'b11;

  // Occupancy ranges 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/srfifo_ctrl.sv
// Occupancy counter, request enables, level flags and (with SRFIFO_ERR_FLAGS_EN)
// sticky overflow/underflow flags for the shift-register FIFO.
module srfifo_ctrl
  import srfifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  output logic             push_ena,
  output logic             pop_ena,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
`ifdef SRFIFO_ERR_FLAGS_EN
  ,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
`endif
);

  logic [CNT_W-1:0] count_nxt;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  // A pop frees a slot in the same cycle, so push at full is legal alongside it.
  assign pop_ena  = pop & ~empty;
  assign push_ena = push & (~full | pop_ena);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push_ena, pop_ena})
      OP_PUSH: count_nxt = count + CNT_W'(1);
      OP_POP:  count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count <= '0;
    else       count <= count_nxt;
  end

`ifdef SRFIFO_ERR_FLAGS_EN
  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop_ena) overflow <= 1'b1;
      else if (err_clr)           overflow <= 1'b0;
      if (pop & empty)            underflow <= 1'b1;
      else if (err_clr)           underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/shift_reg_fifo_pl.sv
// Parametrised shift-register FIFO: mem[0] holds the newest entry, the oldest
// sits at mem[count-1]. Optional error flags: define SRFIFO_ERR_FLAGS_EN.
module shift_reg_fifo_pl
  import srfifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty
`ifdef SRFIFO_ERR_FLAGS_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              push_ena;
  logic              pop_ena;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  rd_idx;

  srfifo_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .rstn         (rstn),
    .push         (push),
    .pop          (pop),
    .push_ena     (push_ena),
    .pop_ena      (pop_ena),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef SRFIFO_ERR_FLAGS_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  // count-1 is only meaningful when non-empty; the empty case reads a don't-care slot.
  assign rd_idx = (count != '0) ? IDX_W'(count - CNT_W'(1)) : '0;

  // NOTE: the storage is reset explicitly because reset must leave every entry at zero, which rules out a RAM macro here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ena) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= push_data;
    end
  end

  // Read uses pre-shift contents, so a simultaneous push never disturbs the pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_ena;
      if (pop_ena) pop_data <= mem[rd_idx];
    end
  end

endmodule
